// File: rtl/regfile_stream_reader_pkg.sv
// Shared types and helpers for the regfile stream reader:
// the FSM state encoding plus count-clamp and address-wrap arithmetic.
package regfile_stream_reader_pkg;

    typedef enum logic [0:0] {
        STATE_IDLE   = 1'b0,
        STATE_STREAM = 1'b1
    } state_e;

    // Limit a requested entry count to the size of the register file.
    function automatic int clamp_count(input int count, input int num_entries);
        int result;
        if (count > num_entries) begin
            result = num_entries;
        end else begin
            result = count;
        end
        return result;
    endfunction

    // Step to the next entry, wrapping past the last entry back to zero.
    // Works for register files whose size is not a power of two.
    function automatic int wrap_inc(input int addr, input int num_entries);
        int result;
        if (addr >= (num_entries - 32'sd1)) begin
            result = 32'sd0;
        end else begin
            result = addr + 32'sd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_stream_reader_oslot.sv
// Output slot of the regfile stream reader: one registered response beat.
// A fetch strobe loads a new beat. A drain strobe without a fetch empties
// the slot. Payload is left untouched on drain so it only moves on a fetch.
module regfile_stream_reader_oslot #(
    parameter int p_data_nbits = 32,
    parameter int p_addr_nbits = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_fetch,
    input  logic                    i_drain,
    input  logic [p_data_nbits-1:0] i_data,
    input  logic [p_addr_nbits-1:0] i_addr,
    input  logic                    i_last,
    output logic                    o_val,
    output logic [p_data_nbits-1:0] o_data,
    output logic [p_addr_nbits-1:0] o_addr,
    output logic                    o_last
);

    logic                    r_val;
    logic [p_data_nbits-1:0] r_data;
    logic [p_addr_nbits-1:0] r_addr;
    logic                    r_last;

    // Slot register: load on fetch, invalidate on a drain that is not refilled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val  <= 1'b0;
            r_data <= {p_data_nbits{1'b0}};
            r_addr <= {p_addr_nbits{1'b0}};
            r_last <= 1'b0;
        end else if (i_fetch) begin
            r_val  <= 1'b1;
            r_data <= i_data;
            r_addr <= i_addr;
            r_last <= i_last;
        end else if (i_drain) begin
            r_val  <= 1'b0;
        end
    end

    assign o_val  = r_val;
    assign o_data = r_data;
    assign o_addr = r_addr;
    assign o_last = r_last;

endmodule

// File: rtl/regfile_stream_reader.sv
// Bulk read-out engine: accepts {start, count}, walks a combinational
// regfile read port with modulo wrap, and streams each entry out as a
// registered val/rdy beat tagged with its address and a last flag.
module regfile_stream_reader
    import regfile_stream_reader_pkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 32,
    localparam int c_addr_nbits  = $clog2(p_num_entries)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_val,
    output logic                    req_rdy,
    input  logic [c_addr_nbits-1:0] req_start,
    input  logic [c_addr_nbits:0]   req_count,
    output logic [c_addr_nbits-1:0] rf_read_addr,
    input  logic [p_data_nbits-1:0] rf_read_data,
    output logic                    resp_val,
    input  logic                    resp_rdy,
    output logic [p_data_nbits-1:0] resp_data,
    output logic [c_addr_nbits-1:0] resp_addr,
    output logic                    resp_last
);

    localparam logic [c_addr_nbits:0] c_cnt_zero = {(c_addr_nbits+1){1'b0}};
    localparam logic [c_addr_nbits:0] c_cnt_one  = {{c_addr_nbits{1'b0}}, 1'b1};

    state_e                  r_state;
    state_e                  w_state_next;
    logic [c_addr_nbits-1:0] r_addr;
    logic [c_addr_nbits:0]   r_remain;

    logic [c_addr_nbits:0]   w_clamped;
    logic [c_addr_nbits:0]   w_remain_src;
    logic [c_addr_nbits:0]   w_remain_after;
    logic [c_addr_nbits-1:0] w_next_addr;
    logic                    w_slot_free;
    logic                    w_fetch;
    logic                    w_drain;
    logic                    w_last;

    assign w_clamped      = (c_addr_nbits+1)'(clamp_count(int'(req_count), p_num_entries));
    assign w_next_addr    = c_addr_nbits'(wrap_inc(int'(rf_read_addr), p_num_entries));
    assign w_remain_after = w_remain_src - c_cnt_one;
    assign w_last         = (w_remain_after == c_cnt_zero);
    assign w_slot_free    = !resp_val || resp_rdy;
    assign w_drain        = resp_val && resp_rdy;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STATE_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: enter STREAM on a non-empty accept, leave on the last handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            STATE_IDLE: begin
                if (req_val && (w_clamped != c_cnt_zero)) begin
                    w_state_next = STATE_STREAM;
                end else begin
                    w_state_next = STATE_IDLE;
                end
            end
            STATE_STREAM: begin
                if (w_drain && resp_last) begin
                    w_state_next = STATE_IDLE;
                end else begin
                    w_state_next = STATE_STREAM;
                end
            end
            default: begin
                w_state_next = STATE_IDLE;
            end
        endcase
    end

    // FSM outputs: request ready, read-port address, and the fetch strobe.
    // In IDLE the accept cycle itself fetches req_start; the slot is always
    // empty there because the last beat drained on the edge into IDLE.
    always_comb begin
        req_rdy      = 1'b0;
        rf_read_addr = r_addr;
        w_remain_src = r_remain;
        w_fetch      = 1'b0;
        case (r_state)
            STATE_IDLE: begin
                req_rdy      = 1'b1;
                rf_read_addr = req_start;
                w_remain_src = w_clamped;
                w_fetch      = req_val && (w_clamped != c_cnt_zero) && w_slot_free;
            end
            STATE_STREAM: begin
                req_rdy      = 1'b0;
                rf_read_addr = r_addr;
                w_remain_src = r_remain;
                w_fetch      = (r_remain != c_cnt_zero) && w_slot_free;
            end
            default: begin
                req_rdy      = 1'b0;
                rf_read_addr = r_addr;
                w_remain_src = r_remain;
                w_fetch      = 1'b0;
            end
        endcase
    end

    // Walk pointer and remaining count advance on every fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr   <= {c_addr_nbits{1'b0}};
            r_remain <= c_cnt_zero;
        end else if (w_fetch) begin
            r_addr   <= w_next_addr;
            r_remain <= w_remain_after;
        end
    end

    regfile_stream_reader_oslot #(
        .p_data_nbits (p_data_nbits),
        .p_addr_nbits (c_addr_nbits)
    ) u_oslot (
        .clk     (clk),
        .rst_n   (reset),
        .i_fetch (w_fetch),
        .i_drain (w_drain),
        .i_data  (rf_read_data),
        .i_addr  (rf_read_addr),
        .i_last  (w_last),
        .o_val   (resp_val),
        .o_data  (resp_data),
        .o_addr  (resp_addr),
        .o_last  (resp_last)
    );

endmodule
